modexp_encrypt: RTL and testbench
=================================

MODEXP_ENCRYPT -- requirements
Module: modexp_encrypt

Interface
REQ-001 Parameter W, default 32: width of base r2, modulus p and key k.
REQ-002 Parameter EW, default 32: width of exponent x; sets fixed iteration count.
REQ-003 Parameter KW, default 4: width of c1, r1 and c2.
REQ-004 clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 start  in  1  request pulse; sampled only in IDLE.
REQ-007 r2  in  W  base, and the reference value for verification.
REQ-008 x  in  EW  secret exponent.
REQ-009 p  in  W  modulus.
REQ-010 c1  in  KW  received cipher to be verified.
REQ-011 r1  in  KW  plaintext to encrypt on success.
REQ-012 busy  out  1  high from the cycle after start is accepted until done.
REQ-013 done  out  1  one-cycle pulse when the result registers update.
REQ-014 true  out  1  verification passed.
REQ-015 err  out  1  modulus was zero.
REQ-016 c2  out  KW  output cipher.

Function
REQ-017 States: IDLE, EXP, CHECK; start in IDLE latches r2, x, p, c1 and r1, then moves to EXP; start outside IDLE is ignored.
REQ-018 On acceptance: res=1 mod p, base=r2 mod p, ebits=x, cnt=0.
REQ-019 EXP runs for exactly EW cycles, LSB first: if ebits[0], res=(res*base) mod p; base=(base*base) mod p; ebits>>=1; cnt++.
REQ-020 Products are 2W bits wide and are reduced modulo p, with no truncation before reduction.
REQ-021 When cnt reaches EW-1, the EXP cycle moves to CHECK; CHECK registers the outputs, pulses done and returns to IDLE.
REQ-022 Latency is fixed: done is high in the cycle EW+1 clocks after the accepting edge, independent of the values of x and p.
REQ-023 Key k = res. r2_new = k[KW-1:0] ^ c1, zero-extended to W bits and compared with the latched r2.
REQ-024 If they are equal: c2 = k[KW-1:0] ^ r1, true=1. Otherwise: c2=0, true=0.
REQ-025 If p=0 at acceptance: full latency still runs, CHECK gives err=1, true=0, c2=0, and no division by zero is evaluated.
REQ-026 p=1 gives k=0. x=0 gives k=1 mod p.
REQ-027 c2, true and err hold their value until the next CHECK; err clears at the next CHECK with p≠0.
REQ-028 start sampled in the same cycle as CHECK is ignored; a new request needs IDLE.

Reset
REQ-029 rst has priority over every other input: state=IDLE, busy=0, done=0, true=0, err=0, c2 = all ones, internal registers = 0.
REQ-030 rst during EXP or CHECK aborts the operation with no done pulse; the outputs take their reset values.

Structure
REQ-031 Package modexp_pkg holds the state enum and the default values of W, EW and KW.
REQ-032 One sub-module, modmul, computes combinationally (a*b) mod p at width W, with guarded output 0 when p=0. It has two instances, for res and for base.

Verification
REQ-033 W=32, EW=32, KW=4: r2=3, x=5, p=7, c1=6, r1=9 -> k=5; done exactly 33 cycles after acceptance; true=1, c2=0xC, err=0.
REQ-034 Same operands with c1=0 -> r2_new=5≠3 -> true=0, c2=0.
REQ-035 r2=3, x=0, p=7, c1=2 -> k=1, r2_new=3 -> true=1, c2=1^r1.
REQ-036 p=0 -> after 33 cycles err=1, true=0, c2=0. A following valid request clears err.
REQ-037 Assert rst at EXP cycle 10 -> no done; c2=0xF, true=0 the next cycle. A new start then runs normally.
REQ-038 Pulse start at EXP cycle 5 and in the CHECK cycle -> both ignored; exactly one done per accepted request.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared state encoding and default widths for the modular-exponentiation encryptor.
package modexp_pkg;

  localparam int W_DEF  = 32;
  localparam int EW_DEF = 32;
  localparam int KW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXP   = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/modexp_encrypt_modmul.sv
// Combinational (a*b) mod p on the full 2W-bit product; yields 0 when p is 0.
module modmul
  import modexp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic [W-1:0] y
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] p_ext;

  assign prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign p_ext = {{W{1'b0}}, p};
  // The guard keeps the remainder operator from ever seeing a zero divisor.
  assign y     = (p == '0) ? '0 : W'(prod % p_ext);

endmodule

// File: rtl/modexp_encrypt.sv
// Fixed-latency LSB-first modular exponentiation, followed by a key check and XOR encryption.
module modexp_encrypt
  import modexp_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int EW = EW_DEF,
  parameter int KW = KW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  r2,
  input  logic [EW-1:0] x,
  input  logic [W-1:0]  p,
  input  logic [KW-1:0] c1,
  input  logic [KW-1:0] r1,
  output logic          busy,
  output logic          done,
  output logic          true,
  output logic          err,
  output logic [KW-1:0] c2
);

  localparam int CW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EW - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  res_q, res_d, base_q, base_d, r2_q, r2_d, p_q, p_d;
  logic [EW-1:0] ebits_q, ebits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] c1_q, c1_d, r1_q, r1_d, c2_q, c2_d;
  logic          done_q, done_d, true_q, true_d, err_q, err_d;

  logic [W-1:0]  res_a, res_b, base_a, base_b, mm_p, res_mm, base_mm, r2_new;

  // In IDLE the multipliers are borrowed to form 1 mod p and r2 mod p for the new request.
  modmul #(.W(W)) u_mul_res  (.a(res_a),  .b(res_b),  .p(mm_p), .y(res_mm));
  modmul #(.W(W)) u_mul_base (.a(base_a), .b(base_b), .p(mm_p), .y(base_mm));

  assign r2_new = W'(res_q[KW-1:0] ^ c1_q);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    base_d  = base_q;
    ebits_d = ebits_q;
    cnt_d   = cnt_q;
    r2_d    = r2_q;
    p_d     = p_q;
    c1_d    = c1_q;
    r1_d    = r1_q;
    c2_d    = c2_q;
    done_d  = 1'b0;
    true_d  = true_q;
    err_d   = err_q;
    res_a   = res_q;
    res_b   = base_q;
    base_a  = base_q;
    base_b  = base_q;
    mm_p    = p_q;
    case (state_q)
      IDLE: begin
        res_a  = W'(1);
        res_b  = W'(1);
        base_a = r2;
        base_b = W'(1);
        mm_p   = p;
        if (start) begin
          r2_d    = r2;
          p_d     = p;
          c1_d    = c1;
          r1_d    = r1;
          res_d   = res_mm;
          base_d  = base_mm;
          ebits_d = x;
          cnt_d   = '0;
          state_d = EXP;
        end
      end
      EXP: begin
        if (ebits_q[0]) res_d = res_mm;
        base_d  = base_mm;
        ebits_d = ebits_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = CHECK;
      end
      CHECK: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (p_q == '0) begin
          err_d  = 1'b1;
          true_d = 1'b0;
          c2_d   = '0;
        end else if (r2_new == r2_q) begin
          err_d  = 1'b0;
          true_d = 1'b1;
          c2_d   = res_q[KW-1:0] ^ r1_q;
        end else begin
          err_d  = 1'b0;
          true_d = 1'b0;
          c2_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      base_q  <= '0;
      ebits_q <= '0;
      cnt_q   <= '0;
      r2_q    <= '0;
      p_q     <= '0;
      c1_q    <= '0;
      r1_q    <= '0;
      c2_q    <= '1;
      done_q  <= 1'b0;
      true_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      base_q  <= base_d;
      ebits_q <= ebits_d;
      cnt_q   <= cnt_d;
      r2_q    <= r2_d;
      p_q     <= p_d;
      c1_q    <= c1_d;
      r1_q    <= r1_d;
      c2_q    <= c2_d;
      done_q  <= done_d;
      true_q  <= true_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign true = true_q;
  assign err  = err_q;
  assign c2   = c2_q;

endmodule

// File: tb/tb_modexp_encrypt.sv
// Directed bench for modexp_encrypt with hand-computed keys and ciphers.
module tb_modexp_encrypt;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] r2 = '0;
  logic [31:0] x = '0;
  logic [31:0] p = '0;
  logic [3:0]  c1 = '0;
  logic [3:0]  r1 = '0;
  logic        busy, done, true, err;
  logic [3:0]  c2;

  int pass_cnt = 0;
  int total    = 0;

  modexp_encrypt #(.W(32), .EW(32), .KW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .r2(r2), .x(x), .p(p), .c1(c1), .r1(r1),
    .busy(busy), .done(done), .true(true), .err(err), .c2(c2)
  );

  always #5 clk = ~clk;

  // Issues one request and returns the number of edges from acceptance to done (0 on timeout).
  task automatic run_req(input logic [31:0] r2v, input logic [31:0] xv, input logic [31:0] pv,
                         input logic [3:0] c1v, input logic [3:0] r1v, output int lat);
    lat = 0;
    @(negedge clk);
    r2 = r2v; x = xv; p = pv; c1 = c1v; r1 = r1v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, true, err, c2} !== {1'b0, 1'b0, 1'b0, 1'b0, 4'hF})
      $display("FAIL reset_outputs: got busy=%0b done=%0b true=%0b err=%0b c2=%h, want 0 0 0 0 f",
               busy, done, true, err, c2);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_match();
    int lat;
    run_req(32'd3, 32'd5, 32'd7, 4'd6, 4'd9, lat);
    total++;
    if (lat !== 33) $display("FAIL match_latency: got %0d want 33", lat); else pass_cnt++;
    total++;
    if ({true, err, c2} !== {1'b1, 1'b0, 4'hC})
      $display("FAIL match_result: got true=%0b err=%0b c2=%h want 1 0 c", true, err, c2);
    else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL match_busy_after_done: got %0b want 0", busy); else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if ({done, true, c2} !== {1'b0, 1'b1, 4'hC})
      $display("FAIL match_hold: got done=%0b true=%0b c2=%h want 0 1 c", done, true, c2);
    else pass_cnt++;
  endtask

  task automatic test_mismatch();
    int lat;
    run_req(32'd3, 32'd5, 32'd7, 4'd0, 4'd9, lat);
    total++;
    if ({lat, true, err, c2} !== {32'd33, 1'b0, 1'b0, 4'h0})
      $display("FAIL mismatch: got lat=%0d true=%0b err=%0b c2=%h want 33 0 0 0", lat, true, err, c2);
    else pass_cnt++;
  endtask

  task automatic test_x_zero();
    int lat;
    run_req(32'd3, 32'd0, 32'd7, 4'd2, 4'd9, lat);
    total++;
    if ({lat, true, c2} !== {32'd33, 1'b1, 4'h8})
      $display("FAIL x_zero: got lat=%0d true=%0b c2=%h want 33 1 8", lat, true, c2);
    else pass_cnt++;
  endtask

  task automatic test_p_one();
    int lat;
    run_req(32'd0, 32'd7, 32'd1, 4'd0, 4'd5, lat);
    total++;
    if ({lat, true, c2} !== {32'd33, 1'b1, 4'h5})
      $display("FAIL p_one: got lat=%0d true=%0b c2=%h want 33 1 5", lat, true, c2);
    else pass_cnt++;
  endtask

  task automatic test_wide_values();
    int lat;
    // 2^10 mod 1000 = 24 -> low nibble 8
    run_req(32'd2, 32'd10, 32'd1000, 4'd10, 4'd3, lat);
    total++;
    if ({true, c2} !== {1'b1, 4'hB})
      $display("FAIL mod_1000: got true=%0b c2=%h want 1 b", true, c2);
    else pass_cnt++;
    // 2^32 mod (2^32-1) = 1; needs the untruncated 64-bit square
    run_req(32'd2, 32'd32, 32'hFFFF_FFFF, 4'd3, 4'd4, lat);
    total++;
    if ({true, c2} !== {1'b1, 4'h5})
      $display("FAIL full_product: got true=%0b c2=%h want 1 5", true, c2);
    else pass_cnt++;
  endtask

  task automatic test_p_zero();
    int lat;
    run_req(32'd3, 32'd5, 32'd0, 4'd6, 4'd9, lat);
    total++;
    if ({lat, err, true, c2} !== {32'd33, 1'b1, 1'b0, 4'h0})
      $display("FAIL p_zero: got lat=%0d err=%0b true=%0b c2=%h want 33 1 0 0", lat, err, true, c2);
    else pass_cnt++;
    run_req(32'd3, 32'd5, 32'd7, 4'd6, 4'd9, lat);
    total++;
    if ({err, true, c2} !== {1'b0, 1'b1, 4'hC})
      $display("FAIL err_clear: got err=%0b true=%0b c2=%h want 0 1 c", err, true, c2);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int dcnt;
    int lat;
    dcnt = 0;
    @(negedge clk);
    r2 = 32'd3; x = 32'd5; p = 32'd7; c1 = 4'd6; r1 = 4'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_after_accept: got %0b want 1", busy); else pass_cnt++;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if ({busy, done, true, err, c2} !== {1'b0, 1'b0, 1'b0, 1'b0, 4'hF})
      $display("FAIL abort_outputs: got busy=%0b done=%0b true=%0b err=%0b c2=%h want 0 0 0 0 f",
               busy, done, true, err, c2);
    else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    total++;
    if (dcnt !== 0) $display("FAIL abort_no_done: got %0d done pulses want 0", dcnt); else pass_cnt++;
    run_req(32'd3, 32'd5, 32'd7, 4'd6, 4'd9, lat);
    total++;
    if ({lat, true, c2} !== {32'd33, 1'b1, 4'hC})
      $display("FAIL after_abort: got lat=%0d true=%0b c2=%h want 33 1 c", lat, true, c2);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dcnt;
    int dcyc;
    dcnt = 0;
    dcyc = 0;
    @(negedge clk);
    r2 = 32'd3; x = 32'd5; p = 32'd7; c1 = 4'd6; r1 = 4'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcnt++;
        dcyc = i;
      end
      if (i == 5) begin
        start = 1'b1; x = 32'd0; c1 = 4'd2;
      end
      if (i == 6) start = 1'b0;
      if (i == 32) start = 1'b1;
      if (i == 33) start = 1'b0;
    end
    total++;
    if ({dcnt, dcyc} !== {32'd1, 32'd33})
      $display("FAIL ignored_starts: got %0d done pulses at cycle %0d want 1 at 33", dcnt, dcyc);
    else pass_cnt++;
    total++;
    if ({busy, true, c2} !== {1'b0, 1'b1, 4'hC})
      $display("FAIL ignored_starts_result: got busy=%0b true=%0b c2=%h want 0 1 c", busy, true, c2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_x_zero();
    test_p_one();
    test_wide_values();
    test_p_zero();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
